// File: rtl/axi_lite_master_arb.sv
// -----------------------------------------------------------------------------
// axi_lite_master_arb
//
// Shares one AXI4-Lite master port among NUM_REQ local requesters. One
// transaction is in flight at a time. The arbiter picks a winner in IDLE and
// registers its command. It then sequences AW/W -> B or AR -> R. Completion is
// signalled with a one-cycle rsp_valid pulse to the owning requester.
//
// Configuration macro:
//   AXIL_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                           undefined -> round-robin starting at rr_ptr
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   req_valid/req_ready   per-requester command handshake (ready is one-hot or 0)
//   req_write             1 = write, 0 = read
//   req_addr/wdata/wstrb  flattened per-requester command fields
//   rsp_valid             one-cycle completion pulse to the owner
//   rsp_rdata, rsp_resp   read data (0 for writes) and BRESP/RRESP
//   AW*/W*/B*/AR*/R*      AXI4-Lite master channels
// -----------------------------------------------------------------------------
module axi_lite_master_arb #(
    parameter int         NUM_REQ       = 2,
    parameter int         DATA_WIDTH    = 32,
    parameter int         ADDRESS_WIDTH = 32,
    parameter logic [2:0] PROT          = 3'b000
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic [ADDRESS_WIDTH-1:0]        AWADDR,
    output logic [2:0]                      AWPROT,
    output logic                            AWVALID,
    input  logic                            AWREADY,
    output logic [DATA_WIDTH-1:0]           WDATA,
    output logic [DATA_WIDTH/8-1:0]         WSTRB,
    output logic                            WVALID,
    input  logic                            WREADY,
    input  logic [1:0]                      BRESP,
    input  logic                            BVALID,
    output logic                            BREADY,
    output logic [ADDRESS_WIDTH-1:0]        ARADDR,
    output logic [2:0]                      ARPROT,
    output logic                            ARVALID,
    input  logic                            ARREADY,
    input  logic [DATA_WIDTH-1:0]           RDATA,
    input  logic [1:0]                      RRESP,
    input  logic                            RVALID,
    output logic                            RREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_RD_ADDR,
        S_WR_RESP,
        S_RD_RESP
    } state_e;

    state_e                   state_q;
    logic [IDX_W-1:0]         owner_q;
    logic                     awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDRESS_WIDTH-1:0] awaddr_q, araddr_q;
    logic [DATA_WIDTH-1:0]    wdata_q, rsp_rdata_q;
    logic [STRB_W-1:0]        wstrb_q;
    logic [NUM_REQ-1:0]       rsp_valid_q;
    logic [1:0]               rsp_resp_q;

    logic                     win_found;
    logic [IDX_W-1:0]         win_idx;

`ifndef AXIL_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]         rr_ptr_q;
`endif

    // Winner search. Iterating from the far end and overwriting leaves the
    // candidate closest to the search start (rr_ptr or index 0) as winner.
    always_comb begin : arbiter
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef AXIL_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
`endif
            if (req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
    end

    // Ready is only offered from IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && win_found && !ARESET) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        owner_q <= win_idx;
`ifndef AXIL_ARB_FIXED_PRIO_EN
                        rr_ptr_q <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
                        if (req_write[win_idx]) begin
                            awaddr_q  <= req_addr[win_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                            wdata_q   <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                            wstrb_q   <= req_wstrb[win_idx*STRB_W +: STRB_W];
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR_ADDR;
                        end else begin
                            araddr_q  <= req_addr[win_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_ADDR;
                        end
                    end
                end
                // A cleared VALID doubles as the channel's done flag, so AW and
                // W can complete in either order or in the same cycle.
                S_WR_ADDR: begin
                    if (AWREADY) awvalid_q <= 1'b0;
                    if (WREADY)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end
                end
                S_RD_ADDR: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (BVALID) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= NUM_REQ'(1) << owner_q;
                        rsp_resp_q  <= BRESP;
                        rsp_rdata_q <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                S_RD_RESP: begin
                    if (RVALID) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= NUM_REQ'(1) << owner_q;
                        rsp_resp_q  <= RRESP;
                        rsp_rdata_q <= RDATA;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign AWADDR    = awaddr_q;
    assign AWPROT    = PROT;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = araddr_q;
    assign ARPROT    = PROT;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_master_arb.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master_arb
//
// Directed bench for axi_lite_master_arb (NUM_REQ=2, 32-bit data/address).
// A small AXI4-Lite slave with per-channel delay knobs answers the DUT.
// Expected values are hand-computed per scenario.
// -----------------------------------------------------------------------------
module tb_axi_lite_master_arb;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [1:0]  req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wstrb;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    int n_cmp = 0;
    int n_err = 0;

    always #5 ACLK = ~ACLK;

    axi_lite_master_arb #(
        .NUM_REQ(2), .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .PROT(3'b000)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    // ---------------- slave model ----------------
    int   aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    int   n_bhs = 0;
    logic aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;

    assign AWREADY = AWVALID && (aw_cnt >= aw_dly);
    assign WREADY  = WVALID  && (w_cnt  >= w_dly);
    assign ARREADY = ARVALID && (ar_cnt >= ar_dly);
    assign BVALID  = b_pend  && (b_cnt  >= b_dly);
    assign RVALID  = r_pend  && (r_cnt  >= r_dly);

    always @(posedge ACLK) begin
        if (ARESET) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else begin
            aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (WVALID  && !WREADY)  ? w_cnt + 1  : 0;
            ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
            if (b_pend) begin
                if (BVALID && BREADY) begin
                    b_pend <= 1'b0; b_cnt <= 0; n_bhs <= n_bhs + 1;
                end else begin
                    b_cnt <= b_cnt + 1;
                end
            end else if ((aw_got || (AWVALID && AWREADY)) && (w_got || (WVALID && WREADY))) begin
                b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (AWVALID && AWREADY) aw_got <= 1'b1;
                if (WVALID && WREADY)   w_got  <= 1'b1;
            end
            if (r_pend) begin
                if (RVALID && RREADY) begin
                    r_pend <= 1'b0; r_cnt <= 0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end else if (ARVALID && ARREADY) begin
                r_pend <= 1'b1; r_cnt <= 0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_valid[i]         = 1'b1;
        req_write[i]         = wr;
        req_addr[i*32 +: 32] = a;
        req_wdata[i*32 +: 32] = d;
        req_wstrb[i*4 +: 4]  = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [1:0] exp_g [4];
    int n_awv, n_wv, n_brdy, n_arv, n_rrdy, bhs0;
    logic got;

    initial begin
`ifdef AXIL_ARB_FIXED_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        ARESET = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        BRESP = 2'd0; RRESP = 2'd0; RDATA = '0;

        // ---- reset state ----
        step(); step();
        req_valid = 2'b01;
        #1;
        check("rst_req_ready", req_ready, 2'b00);
        req_valid = '0;
        check("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 5'b0);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp", {rsp_rdata, rsp_resp}, 34'h0);
        check("rst_addr", {AWADDR, ARADDR}, 64'h0);
        check("rst_wdata", {WDATA, WSTRB}, 36'h0);
        ARESET = 1'b0;
        step();

        // ---- 1: single write, zero-wait ----
        set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        #1;
        check("t1_grant", req_ready, 2'b01);
        step(); req_valid = '0;
        check("t1_c1_awv_wv", {AWVALID, WVALID}, 2'b11);
        check("t1_c1_awaddr", AWADDR, 32'h10);
        check("t1_c1_wdata", {WDATA, WSTRB}, {32'hDEADBEEF, 4'hF});
        step();
        check("t1_c2_bready", {AWVALID, WVALID, BREADY}, 3'b001);
        check("t1_c2_no_rsp", rsp_valid, 2'b00);
        step();
        check("t1_c3_rsp_valid", rsp_valid, 2'b01);
        check("t1_c3_rsp", {rsp_rdata, rsp_resp}, 34'h0);
        step();
        check("t1_c4_pulse_end", rsp_valid, 2'b00);

        // ---- 2: single read ----
        RDATA = 32'h12345678; RRESP = 2'd2;
        set_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
        #1;
        check("t2_grant", req_ready, 2'b10);
        step(); req_valid = '0;
        check("t2_c1_arvalid", {ARVALID, AWVALID}, 2'b10);
        check("t2_c1_araddr", ARADDR, 32'h20);
        step();
        check("t2_c2_rready", {ARVALID, RREADY}, 2'b01);
        step();
        check("t2_c3_rsp_valid", rsp_valid, 2'b10);
        check("t2_c3_rdata", rsp_rdata, 32'h12345678);
        check("t2_c3_resp", rsp_resp, 2'd2);

        // ---- 3a: W accepted 3 cycles before AW ----
        aw_dly = 3; w_dly = 0; BRESP = 2'd1; bhs0 = n_bhs;
        set_req(0, 1'b1, 32'h30, 32'h11112222, 4'h5);
        #1;
        check("t3a_grant", req_ready, 2'b01);
        step(); req_valid = '0;
        check("t3a_c1", {AWVALID, WVALID}, 2'b11);
        for (int c = 2; c <= 4; c++) begin
            step();
            check($sformatf("t3a_c%0d_valids", c), {AWVALID, WVALID}, 2'b10);
            check($sformatf("t3a_c%0d_awaddr", c), AWADDR, 32'h30);
        end
        step();
        check("t3a_c5_bready", {AWVALID, WVALID, BREADY}, 3'b001);
        step();
        check("t3a_c6_rsp", {rsp_valid, rsp_resp}, {2'b01, 2'd1});
        check("t3a_c6_rdata", rsp_rdata, 32'h0);
        step();
        check("t3a_c7_pulse_end", rsp_valid, 2'b00);
        check("t3a_b_count", n_bhs - bhs0, 1);

        // ---- 3b: AW accepted 3 cycles before W ----
        aw_dly = 0; w_dly = 3; BRESP = 2'd0; bhs0 = n_bhs;
        set_req(0, 1'b1, 32'h34, 32'h33334444, 4'hA);
        #1;
        check("t3b_grant", req_ready, 2'b01);
        step(); req_valid = '0;
        check("t3b_c1", {AWVALID, WVALID}, 2'b11);
        for (int c = 2; c <= 4; c++) begin
            step();
            check($sformatf("t3b_c%0d_valids", c), {AWVALID, WVALID}, 2'b01);
            check($sformatf("t3b_c%0d_wdata", c), {WDATA, WSTRB}, {32'h33334444, 4'hA});
        end
        step();
        check("t3b_c5_bready", {AWVALID, WVALID, BREADY}, 3'b001);
        step();
        check("t3b_c6_rsp", rsp_valid, 2'b01);
        step();
        check("t3b_b_count", n_bhs - bhs0, 1);
        w_dly = 0;

        // ---- 4: contention, both requesters continuously valid ----
        ARESET = 1'b1; step(); ARESET = 1'b0;
        RDATA = 32'hA5A50000; RRESP = 2'd0;
        set_req(0, 1'b0, 32'h40, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h44, 32'h0, 4'h0);
        #1;
        for (int g = 0; g < 4; g++) begin
            int w;
            w = 0;
            while (req_ready == 2'b00 && w < 10) begin
                step();
                w++;
            end
            check($sformatf("t4_grant%0d", g), req_ready, exp_g[g]);
            if (g > 0) check($sformatf("t4_b2b_rsp%0d", g), rsp_valid, exp_g[g-1]);
            step();
        end
        req_valid = '0;
        step(); step();
        check("t4_last_rsp", rsp_valid, exp_g[3]);
        step();

        // ---- 5: backpressure, write then read ----
        aw_dly = 5; w_dly = 5; b_dly = 5;
        set_req(0, 1'b1, 32'hA4, 32'hCAFEF00D, 4'h3);
        #1;
        check("t5w_grant", req_ready, 2'b01);
        step(); req_valid = '0;
        n_awv = 0; n_wv = 0; n_brdy = 0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (rsp_valid != 2'b00) got = 1'b1;
            else begin
                if (AWVALID) begin n_awv++; check("t5w_awaddr", AWADDR, 32'hA4); end
                if (WVALID) begin n_wv++; check("t5w_wdata", {WDATA, WSTRB}, {32'hCAFEF00D, 4'h3}); end
                if (BREADY) n_brdy++;
                step();
            end
        end
        check("t5w_done", got, 1'b1);
        check("t5w_awvalid_cycles", n_awv, 6);
        check("t5w_wvalid_cycles", n_wv, 6);
        check("t5w_bready_cycles", n_brdy, 6);
        check("t5w_rsp", {rsp_valid, rsp_resp}, {2'b01, 2'd0});
        ar_dly = 5; r_dly = 5; RDATA = 32'h0BADF00D; RRESP = 2'd0;
        set_req(1, 1'b0, 32'hB8, 32'h0, 4'h0);
        #1;
        check("t5r_grant", req_ready, 2'b10);
        step(); req_valid = '0;
        n_arv = 0; n_rrdy = 0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (rsp_valid != 2'b00) got = 1'b1;
            else begin
                if (ARVALID) begin n_arv++; check("t5r_araddr", ARADDR, 32'hB8); end
                if (RREADY) n_rrdy++;
                step();
            end
        end
        check("t5r_done", got, 1'b1);
        check("t5r_arvalid_cycles", n_arv, 6);
        check("t5r_rready_cycles", n_rrdy, 6);
        check("t5r_rsp", {rsp_valid, rsp_rdata}, {2'b10, 32'h0BADF00D});
        step();

        // ---- 6: reset during WR_RESP ----
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; b_dly = 5;
        set_req(0, 1'b1, 32'h50, 32'h55AA55AA, 4'hF);
        #1;
        check("t6_grant", req_ready, 2'b01);
        step(); req_valid = '0;
        step();
        check("t6_in_wr_resp", BREADY, 1'b1);
        ARESET = 1'b1;
        step();
        check("t6_rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 5'b0);
        check("t6_rst_rsp", {rsp_valid, rsp_rdata, rsp_resp}, 36'h0);
        check("t6_rst_addr", {AWADDR, ARADDR}, 64'h0);
        check("t6_rst_wdata", {WDATA, WSTRB}, 36'h0);
        check("t6_rst_req_ready", req_ready, 2'b00);
        ARESET = 1'b0; b_dly = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("t6_no_pulse%0d", c), {rsp_valid, BREADY}, 3'b000);
        end
        RDATA = 32'h0000600D;
        set_req(1, 1'b0, 32'h60, 32'h0, 4'h0);
        #1;
        check("t6_regrant", req_ready, 2'b10);
        step(); req_valid = '0;
        step(); step();
        check("t6_after_rsp", {rsp_valid, rsp_rdata}, {2'b10, 32'h0000600D});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
